// File: rtl/memmap_pkg.sv
// Shared memory-map definitions: FSM encoding, board region constants and default wait states.
package memmap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [19:0] RAM_BASE  = 20'h00000;
    localparam logic [19:0] RAM_MASK  = 20'hFC000;
    localparam logic [19:0] TEXT_BASE = 20'hB8000;
    localparam logic [19:0] TEXT_MASK = 20'hFF000;
    localparam logic [19:0] FONT_BASE = 20'hC0000;
    localparam logic [19:0] FONT_MASK = 20'hFF000;
    localparam logic [19:0] BIOS_BASE = 20'hFF000;
    localparam logic [19:0] BIOS_MASK = 20'hFF000;

    // Region 0 is lowest priority index, so RAM wins any overlap.
    localparam logic [79:0] BOARD_BASE = {BIOS_BASE, FONT_BASE, TEXT_BASE, RAM_BASE};
    localparam logic [79:0] BOARD_MASK = {BIOS_MASK, FONT_MASK, TEXT_MASK, RAM_MASK};
    localparam logic [15:0] DEF_WAITS  = {4'd1, 4'd2, 4'd1, 4'd0};

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational priority decoder: address -> one-hot region hit, lowest index wins.
module mem_bus_decode
    import memmap_pkg::*;
#(
    parameter int                      ADDR_W = 20,
    parameter int                      NREG   = 4,
    parameter logic [NREG*ADDR_W-1:0]  BASE   = BOARD_BASE,
    parameter logic [NREG*ADDR_W-1:0]  MASK   = BOARD_MASK
) (
    input  logic [ADDR_W-1:0] address,
    output logic [NREG-1:0]   hit,
    output logic              hit_vld
);

    always_comb begin
        hit     = '0;
        hit_vld = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (!hit_vld &&
                ((address & MASK[i*ADDR_W +: ADDR_W]) ==
                 (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]))) begin
                hit[i]  = 1'b1;
                hit_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus.sv
// CPU memory-map decoder and wait-state sequencer; one access in flight, requests during busy dropped.
// Mapped access completes W+2 cycles after the request, unmapped after 1; faults are sticky.
module mem_bus
    import memmap_pkg::*;
#(
    parameter int                      ADDR_W   = 20,
    parameter int                      DATA_W   = 8,
    parameter int                      NREG     = 4,
    parameter logic [NREG*ADDR_W-1:0]  BASE     = BOARD_BASE,
    parameter logic [NREG*ADDR_W-1:0]  MASK     = BOARD_MASK,
    parameter logic [NREG*4-1:0]       WAITS    = DEF_WAITS,
    parameter logic [DATA_W-1:0]       DEF_DATA = 8'hFF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cpu_req,
    input  logic [ADDR_W-1:0]      cpu_address,
    input  logic                   cpu_we,
    input  logic [DATA_W-1:0]      cpu_out,
    output logic [DATA_W-1:0]      cpu_in,
    output logic                   cpu_ready,
    output logic                   busy,
    output logic [ADDR_W-1:0]      reg_a,
    output logic [DATA_W-1:0]      reg_d,
    output logic [NREG-1:0]        reg_sel,
    output logic [NREG-1:0]        reg_w,
    input  logic [NREG*DATA_W-1:0] reg_q,
    output logic                   fault,
    output logic [ADDR_W-1:0]      fault_addr,
    input  logic                   fault_clr
);

    state_t            state, state_nxt;
    logic [NREG-1:0]   hit, sel_q;
    logic              hit_vld, we_q;
    logic [3:0]        cnt, hit_wait;
    logic [DATA_W-1:0] rd_sel;
    logic              start;

    mem_bus_decode #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG),
        .BASE   (BASE),
        .MASK   (MASK)
    ) u_decode (
        .address (cpu_address),
        .hit     (hit),
        .hit_vld (hit_vld)
    );

    assign start = (state == IDLE) && cpu_req;

    always_comb begin
        hit_wait = '0;
        rd_sel   = DEF_DATA;
        for (int i = 0; i < NREG; i++) begin
            if (hit[i])   hit_wait = WAITS[i*4 +: 4];
            if (sel_q[i]) rd_sel   = reg_q[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Strobes are decoded from registered state so reset removes them immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req) state_nxt = hit_vld ? ACCESS : DONE;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy      = (state != IDLE);
        cpu_ready = (state == DONE);
        reg_sel   = (state == ACCESS) ? sel_q : '0;
        reg_w     = (state == ACCESS && cnt == 4'd0 && we_q) ? sel_q : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_a  <= '0;
            reg_d  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            cnt    <= '0;
            cpu_in <= DEF_DATA;
        end else if (start) begin
            reg_a <= cpu_address;
            reg_d <= cpu_out;
            we_q  <= cpu_we;
            sel_q <= hit;
            cnt   <= hit_wait;
            if (!hit_vld && !cpu_we) cpu_in <= DEF_DATA;
        end else if (state == ACCESS) begin
            if (cnt == 4'd0) begin
                if (!we_q) cpu_in <= rd_sel;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // A clear in the same cycle as a new fault wins; the new fault is not recorded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end else if (start && !hit_vld) begin
            fault <= 1'b1;
            if (!fault) fault_addr <= cpu_address;
        end
    end

endmodule

// File: tb/tb_mem_bus.sv
// Directed plus randomized bench for mem_bus against a region-table reference model.
module tb_mem_bus;

    localparam logic [79:0] TB_BASE  = {20'hFF000, 20'h00100, 20'hB8000, 20'h00000};
    localparam logic [79:0] TB_MASK  = {20'hFF000, 20'hFFF00, 20'hFF000, 20'hFC000};
    localparam logic [15:0] TB_WAITS = {4'd1, 4'd2, 4'd3, 4'd0};

    logic        clock = 1'b0;
    logic        reset_n, cpu_req, cpu_we, cpu_ready, busy, fault, fault_clr;
    logic [19:0] cpu_address, reg_a, fault_addr;
    logic [7:0]  cpu_out, cpu_in, reg_d;
    logic [3:0]  reg_sel, reg_w;
    logic [31:0] reg_q;

    logic [19:0] base_m  [4] = '{20'h00000, 20'hB8000, 20'h00100, 20'hFF000};
    logic [19:0] mask_m  [4] = '{20'hFC000, 20'hFF000, 20'hFFF00, 20'hFF000};
    int          waits_m [4] = '{0, 3, 2, 1};

    logic [7:0]  exp_in;
    logic        fault_m;
    logic [19:0] fault_addr_m;
    int          errors = 0;
    int          checks = 0;

    mem_bus #(
        .ADDR_W(20), .DATA_W(8), .NREG(4),
        .BASE(TB_BASE), .MASK(TB_MASK), .WAITS(TB_WAITS), .DEF_DATA(8'hFF)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_address(cpu_address),
        .cpu_we(cpu_we), .cpu_out(cpu_out), .cpu_in(cpu_in), .cpu_ready(cpu_ready),
        .busy(busy), .reg_a(reg_a), .reg_d(reg_d), .reg_sel(reg_sel), .reg_w(reg_w),
        .reg_q(reg_q), .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int region_of(input logic [19:0] addr);
        for (int i = 0; i < 4; i++)
            if ((addr & mask_m[i]) == (base_m[i] & mask_m[i])) return i;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int r);
        logic [3:0] v;
        v = 4'b0001;
        return v << r;
    endfunction

    // One complete CPU transaction; hold keeps cpu_req asserted with a scrambled address while busy.
    task automatic access(input logic [19:0] addr, input logic we, input logic [7:0] data,
                          input logic clr, input logic hold);
        int r, w, exp_k, ready_k, wpulses, wk;
        logic [3:0] exp_sel;
        r     = region_of(addr);
        w     = (r >= 0) ? waits_m[r] : 0;
        exp_k = (r >= 0) ? w + 2 : 1;
        if (clr) fault_m = 1'b0;
        else if (r < 0) begin
            if (!fault_m) fault_addr_m = addr;
            fault_m = 1'b1;
        end
        if (!we) exp_in = (r >= 0) ? reg_q[r*8 +: 8] : 8'hFF;

        cpu_req = 1'b1; cpu_address = addr; cpu_we = we; cpu_out = data; fault_clr = clr;
        tick();
        if (!hold) cpu_req = 1'b0;
        fault_clr   = 1'b0;
        cpu_address = 20'($urandom);
        cpu_out     = 8'($urandom);
        cpu_we      = 1'($urandom);

        ready_k = 0; wpulses = 0; wk = 0;
        for (int k = 1; k <= 20 && ready_k == 0; k++) begin
            exp_sel = (r >= 0 && k <= w + 1) ? onehot(r) : 4'b0000;
            check("reg_sel", 32'(reg_sel), 32'(exp_sel));
            check("busy", 32'(busy), 32'd1);
            if (reg_w != 4'b0000) begin
                wpulses++;
                wk = k;
                check("reg_w_val", 32'(reg_w), (r >= 0) ? 32'(onehot(r)) : 32'd0);
            end
            if (cpu_ready) begin
                ready_k = k;
                cpu_req = 1'b0;
            end else begin
                tick();
            end
        end
        check("ready_latency", ready_k, exp_k);
        check("w_pulses", wpulses, (we && r >= 0) ? 1 : 0);
        if (we && r >= 0) check("w_cycle", wk, w + 1);
        check("cpu_in", 32'(cpu_in), 32'(exp_in));
        check("reg_a", 32'(reg_a), 32'(addr));
        check("reg_d", 32'(reg_d), 32'(data));
        check("fault", 32'(fault), 32'(fault_m));
        check("fault_addr", 32'(fault_addr), 32'(fault_addr_m));
        tick();
        check("ready_pulse_end", 32'(cpu_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        if (hold) begin
            repeat (3) begin
                tick();
                check("no_second_ready", 32'(cpu_ready), 32'd0);
            end
        end
    endtask

    initial begin
        logic [19:0] a;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_address = '0; cpu_we = 1'b0;
        cpu_out = '0; fault_clr = 1'b0;
        reg_q = {8'h44, 8'h33, 8'h22, 8'h5A};
        exp_in = 8'hFF; fault_m = 1'b0; fault_addr_m = '0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_in", 32'(cpu_in), 32'hFF);
        check("rst_sel", 32'(reg_sel), 32'd0);
        check("rst_w", 32'(reg_w), 32'd0);
        check("rst_a", 32'(reg_a), 32'd0);
        check("rst_d", 32'(reg_d), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_addr", 32'(fault_addr), 32'd0);
        reset_n = 1'b1;
        tick();

        access(20'h00010, 1'b0, 8'h00, 1'b0, 1'b0);   // RAM read, zero waits
        access(20'hB8002, 1'b1, 8'h41, 1'b0, 1'b0);   // TEXT write, three waits
        access(20'h50000, 1'b0, 8'h00, 1'b0, 1'b0);   // unmapped, first fault
        access(20'h60000, 1'b0, 8'h00, 1'b0, 1'b0);   // fault_addr keeps first
        access(20'h00100, 1'b0, 8'h00, 1'b0, 1'b0);   // overlap regions 0 and 2

        // Reset during the second ACCESS cycle of a three-wait write.
        cpu_req = 1'b1; cpu_address = 20'hB8002; cpu_we = 1'b1; cpu_out = 8'h41;
        tick();
        cpu_req = 1'b0;
        check("mid_sel_before", 32'(reg_sel), 32'b0010);
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_w", 32'(reg_w), 32'd0);
        check("mid_sel", 32'(reg_sel), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(cpu_ready), 32'd0);
        check("mid_cpu_in", 32'(cpu_in), 32'hFF);
        check("mid_a", 32'(reg_a), 32'd0);
        check("mid_d", 32'(reg_d), 32'd0);
        check("mid_fault", 32'(fault), 32'd0);
        check("mid_fault_addr", 32'(fault_addr), 32'd0);
        repeat (3) begin
            tick();
            check("mid_w_hold", 32'(reg_w), 32'd0);
        end
        reset_n = 1'b1;
        exp_in = 8'hFF; fault_m = 1'b0; fault_addr_m = '0;
        tick();
        check("post_rst_w", 32'(reg_w), 32'd0);

        access(20'h50000, 1'b0, 8'h00, 1'b0, 1'b0);   // set fault again
        access(20'h60000, 1'b0, 8'h00, 1'b1, 1'b1);   // clear wins, req held while busy
        access(20'h70000, 1'b0, 8'h00, 1'b0, 1'b0);   // fault_addr reloads after clear

        for (int n = 0; n < 40; n++) begin
            reg_q = $urandom;
            case ($urandom_range(0, 4))
                0:       a = 20'($urandom_range(0, 16'h3FFF));
                1:       a = 20'hB8000 | 20'($urandom_range(0, 12'hFFF));
                2:       a = 20'hFF000 | 20'($urandom_range(0, 12'hFFF));
                3:       a = 20'h00100 | 20'($urandom_range(0, 8'hFF));
                default: a = 20'($urandom);
            endcase
            access(a, 1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
